// File: rtl/processor_pkg.sv
// Shared definitions for the 8-bit accumulator processor.
// Contents: opcode constants, A-mux select encodings, the controller state
// encoding and an opcode-to-execute-state helper.
package processor_pkg;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_INPUT = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam logic [1:0] ASEL_SUB   = 2'd0;
  localparam logic [1:0] ASEL_INPUT = 2'd1;
  localparam logic [1:0] ASEL_MEM   = 2'd2;
  localparam logic [1:0] ASEL_ZERO  = 2'd3;

  typedef enum logic [3:0] {
    S_START      = 4'd0,
    S_FETCH      = 4'd1,
    S_DECODE     = 4'd2,
    S_LOAD       = 4'd3,
    S_STORE      = 4'd4,
    S_ADD        = 4'd5,
    S_SUB        = 4'd6,
    S_INPUT_WAIT = 4'd7,
    S_INPUT_LOAD = 4'd8,
    S_JZ         = 4'd9,
    S_JPOS       = 4'd10,
    S_HALT       = 4'd11
  } state_t;

  // Maps an opcode to the state that executes it (INPUT enters its wait state).
  function automatic state_t decode_op(input logic [2:0] op);
    case (op)
      OP_LOAD:  return S_LOAD;
      OP_STORE: return S_STORE;
      OP_ADD:   return S_ADD;
      OP_SUB:   return S_SUB;
      OP_INPUT: return S_INPUT_WAIT;
      OP_JZ:    return S_JZ;
      OP_JPOS:  return S_JPOS;
      default:  return S_HALT;
    endcase
  endfunction

endpackage

// File: rtl/enter_sync_edge.sv
// Enter key synchroniser and rising-edge detector.
// Ports: clk, clear (async active-high reset), enter (asynchronous key),
//        enter_pulse (one-cycle pulse on a synchronised rising edge).
module enter_sync_edge (
  input  logic clk,
  input  logic clear,
  input  logic enter,
  output logic enter_pulse
);

  logic sync1;
  logic sync2;
  logic delayed;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      delayed <= 1'b0;
    end else begin
      sync1   <= enter;
      sync2   <= sync1;
      delayed <= sync2;
    end
  end

  assign enter_pulse = sync2 & ~delayed;

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute controller for the 8-bit accumulator processor.
// Inputs : clk, clear (async active-high reset), IR (instruction register),
//          Aeq0/Apos (accumulator flags), Enter (asynchronous user key).
// Outputs: IRload, PCload, JMPmux, clearPC, Meminst, MemWr, Asel, loadA,
//          clearA, sub, Halt (datapath controls), state (debug code),
//          instr_count (retired instructions, wraps).
module control_unit
  import processor_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [N-1:0]     IR,
  input  logic             Aeq0,
  input  logic             Apos,
  input  logic             Enter,
  output logic             IRload,
  output logic             PCload,
  output logic             JMPmux,
  output logic             clearPC,
  output logic             Meminst,
  output logic             MemWr,
  output logic [1:0]       Asel,
  output logic             loadA,
  output logic             clearA,
  output logic             sub,
  output logic             Halt,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  state_t     cur_state;
  state_t     next_state;
  logic [2:0] opcode;
  logic       enter_pulse;
  logic       unused_addr;

  assign opcode      = IR[N-1:N-3];
  // The address field drives the datapath directly; the controller ignores it.
  assign unused_addr = ^IR[N-4:0];
  assign state       = cur_state;

  enter_sync_edge u_enter (
    .clk         (clk),
    .clear       (clear),
    .enter       (Enter),
    .enter_pulse (enter_pulse)
  );

  always_ff @(posedge clk or posedge clear) begin
    if (clear) cur_state <= S_START;
    else       cur_state <= next_state;
  end

  // Every path into FETCH other than from START retires one instruction.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      instr_count <= '0;
    end else if (next_state == S_FETCH && cur_state != S_START) begin
      instr_count <= instr_count + CNT_W'(1);
    end
  end

  always_comb begin
    next_state = S_START;
    IRload     = 1'b0;
    PCload     = 1'b0;
    JMPmux     = 1'b0;
    clearPC    = 1'b0;
    Meminst    = 1'b0;
    MemWr      = 1'b0;
    Asel       = ASEL_SUB;
    loadA      = 1'b0;
    clearA     = 1'b0;
    sub        = 1'b0;
    Halt       = 1'b0;
    case (cur_state)
      S_START: begin
        clearA     = 1'b1;
        clearPC    = 1'b1;
        next_state = S_FETCH;
      end
      S_FETCH: begin
        Meminst    = 1'b1;
        IRload     = 1'b1;
        PCload     = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        next_state = decode_op(opcode);
      end
      S_LOAD: begin
        Asel       = ASEL_MEM;
        loadA      = 1'b1;
        next_state = S_FETCH;
      end
      S_STORE: begin
        MemWr      = 1'b1;
        next_state = S_FETCH;
      end
      S_ADD: begin
        loadA      = 1'b1;
        next_state = S_FETCH;
      end
      S_SUB: begin
        sub        = 1'b1;
        loadA      = 1'b1;
        next_state = S_FETCH;
      end
      S_INPUT_WAIT: begin
        Asel       = ASEL_INPUT;
        next_state = enter_pulse ? S_INPUT_LOAD : S_INPUT_WAIT;
      end
      S_INPUT_LOAD: begin
        Asel       = ASEL_INPUT;
        loadA      = 1'b1;
        next_state = S_FETCH;
      end
      S_JZ: begin
        JMPmux     = 1'b1;
        PCload     = Aeq0;
        next_state = S_FETCH;
      end
      S_JPOS: begin
        JMPmux     = 1'b1;
        PCload     = Apos;
        next_state = S_FETCH;
      end
      S_HALT: begin
        Halt       = 1'b1;
        next_state = S_HALT;
      end
      default: next_state = S_START;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: expected per-cycle state, outputs and
// retired count are queued as stimulus is driven and compared on the falling edge.
module tb_control_unit;
  import processor_pkg::*;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] IR = '0;
  logic       Aeq0 = 1'b0;
  logic       Apos = 1'b0;
  logic       Enter = 1'b0;
  logic       IRload, PCload, JMPmux, clearPC, Meminst, MemWr;
  logic [1:0] Asel;
  logic       loadA, clearA, sub, Halt;
  logic [3:0] state;
  logic [7:0] instr_count;

  always #5 clk = ~clk;

  control_unit #(.N(8), .CNT_W(8)) dut (
    .clk(clk), .clear(clear), .IR(IR), .Aeq0(Aeq0), .Apos(Apos), .Enter(Enter),
    .IRload(IRload), .PCload(PCload), .JMPmux(JMPmux), .clearPC(clearPC),
    .Meminst(Meminst), .MemWr(MemWr), .Asel(Asel), .loadA(loadA),
    .clearA(clearA), .sub(sub), .Halt(Halt), .state(state),
    .instr_count(instr_count)
  );

  typedef struct {
    logic [3:0]  st;
    logic [11:0] outs;
    logic [7:0]  cnt;
  } exp_t;

  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_cnt = '0;
  logic [11:0] dut_outs;

  assign dut_outs = {IRload, PCload, JMPmux, clearPC, Meminst, MemWr,
                     Asel, loadA, clearA, sub, Halt};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output vector each state should present, written from the state table.
  function automatic logic [11:0] exp_outs(input logic [3:0] st, input logic a0, input logic ap);
    logic irl, pcl, jm, cpc, mi, mw, la, ca, sb_, h;
    logic [1:0] as;
    {irl, pcl, jm, cpc, mi, mw, la, ca, sb_, h} = '0;
    as = 2'd0;
    case (st)
      S_START:      begin ca = 1'b1; cpc = 1'b1; end
      S_FETCH:      begin mi = 1'b1; irl = 1'b1; pcl = 1'b1; end
      S_LOAD:       begin as = 2'd2; la = 1'b1; end
      S_STORE:      mw = 1'b1;
      S_ADD:        la = 1'b1;
      S_SUB:        begin sb_ = 1'b1; la = 1'b1; end
      S_INPUT_WAIT: as = 2'd1;
      S_INPUT_LOAD: begin as = 2'd1; la = 1'b1; end
      S_JZ:         begin jm = 1'b1; pcl = a0; end
      S_JPOS:       begin jm = 1'b1; pcl = ap; end
      S_HALT:       h = 1'b1;
      default:      ;
    endcase
    return {irl, pcl, jm, cpc, mi, mw, as, la, ca, sb_, h};
  endfunction

  function automatic state_t exec_of(input logic [2:0] op);
    case (op)
      3'b000:  return S_LOAD;
      3'b001:  return S_STORE;
      3'b010:  return S_ADD;
      3'b011:  return S_SUB;
      3'b100:  return S_INPUT_WAIT;
      3'b101:  return S_JZ;
      3'b110:  return S_JPOS;
      default: return S_HALT;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("state", 32'(state), 32'(e.st));
      check("outs", 32'(dut_outs), 32'(e.outs));
      check("count", 32'(instr_count), 32'(e.cnt));
    end
  end

  // One clock: queue what should be visible after the next rising edge,
  // then return just after the falling-edge comparison.
  task automatic cyc(input state_t s);
    exp_t e;
    @(posedge clk);
    #1;
    e.st   = s;
    e.outs = exp_outs(s, Aeq0, Apos);
    e.cnt  = exp_cnt;
    sb.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [2:0] op, input logic [4:0] addr,
                           input logic a0, input logic ap);
    IR = {op, addr}; Aeq0 = a0; Apos = ap;
    cyc(S_FETCH);
    cyc(S_DECODE);
    cyc(exec_of(op));
    if (op != 3'b111 && op != 3'b100) exp_cnt = exp_cnt + 8'd1;
  endtask

  task automatic release_clear();
    @(negedge clk);
    #1;
    clear   = 1'b0;
    exp_cnt = '0;
    #1;
    check("start_after_release", 32'(state), 32'(S_START));
  endtask

  initial begin
    #2;
    clear = 1'b1;
    #2;
    check("reset_state", 32'(state), 32'(S_START));
    check("reset_outs", 32'(dut_outs), 32'(exp_outs(S_START, 1'b0, 1'b0)));
    check("reset_count", 32'(instr_count), 32'd0);
    @(posedge clk);
    release_clear();

    run_instr(3'b010, 5'b00011, 1'b0, 1'b1);
    run_instr(3'b011, 5'b00100, 1'b1, 1'b0);
    run_instr(3'b000, 5'b00001, 1'b0, 1'b0);
    run_instr(3'b001, 5'b00010, 1'b0, 1'b0);

    run_instr(3'b101, 5'b01010, 1'b1, 1'b0);
    run_instr(3'b101, 5'b01010, 1'b0, 1'b1);
    run_instr(3'b110, 5'b01010, 1'b0, 1'b1);
    run_instr(3'b110, 5'b01010, 1'b1, 1'b0);

    // INPUT with Enter already high: its edge lands before INPUT_WAIT and is lost.
    Enter = 1'b1;
    run_instr(3'b100, 5'b00000, 1'b0, 1'b0);
    repeat (4) cyc(S_INPUT_WAIT);
    Enter = 1'b0;
    repeat (3) cyc(S_INPUT_WAIT);
    Enter = 1'b1;
    cyc(S_INPUT_WAIT);
    cyc(S_INPUT_WAIT);
    cyc(S_INPUT_LOAD);
    exp_cnt = exp_cnt + 8'd1;
    Enter = 1'b0;

    // 256 more instructions carry the count through 255 -> 0.
    for (int unsigned i = 0; i < 256; i++) run_instr(3'b010, 5'(i), 1'b0, 1'b0);

    // Clear during STORE must drop the write strobe without waiting for a clock.
    run_instr(3'b001, 5'b00111, 1'b0, 1'b0);
    clear = 1'b1;
    #1;
    check("store_clr_memwr", 32'(MemWr), 32'd0);
    check("store_clr_state", 32'(state), 32'(S_START));
    check("store_clr_count", 32'(instr_count), 32'd0);
    release_clear();

    run_instr(3'b010, 5'b00001, 1'b0, 1'b0);
    run_instr(3'b111, 5'b00000, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 20; i++) begin
      Enter = i[0];
      Aeq0  = 1'($urandom_range(0, 1));
      Apos  = 1'($urandom_range(0, 1));
      cyc(S_HALT);
    end
    clear = 1'b1;
    #1;
    check("halt_clr_state", 32'(state), 32'(S_START));
    check("halt_clr_halt", 32'(Halt), 32'd0);
    release_clear();
    Enter = 1'b0;
    run_instr(3'b011, 5'b00101, 1'b0, 1'b0);
    cyc(S_FETCH);

    check("queue_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Finite-state controller for the 8-bit accumulator processor.
- Drives the accumulator datapath through these signals: A-mux select, A load, A clear, add/sub select, memory and PC strobes.
- Consumes the datapath status flags Aeq0 and Apos, the instruction register contents, and a user Enter key.
- Implements the fetch/decode/execute sequence for the 8-instruction set, including the blocking INPUT handshake and the conditional jumps.

Parameters:
- N, 8, instruction/data width; opcode = IR[N-1:N-3], address = IR[N-4:0].
- CNT_W, 8, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- clear  in  1  reset; asynchronous, active-high.
- IR  in  N  instruction register contents (IROut).
- Aeq0  in  1  accumulator-is-zero flag from the datapath.
- Apos  in  1  accumulator-is-positive flag from the datapath.
- Enter  in  1  asynchronous user key, active-high.
- IRload  out  1  load IR from memory.
- PCload  out  1  load PC.
- JMPmux  out  1  PC source: 0 = PC+1, 1 = IR address field.
- clearPC  out  1  clear PC.
- Meminst  out  1  memory address source: 1 = PC, 0 = IR address field.
- MemWr  out  1  memory write strobe (stores A).
- Asel  out  2  A-mux select: 0 = SubOut, 1 = Input, 2 = memory/IROut, 3 = zero.
- loadA  out  1  accumulator load.
- clearA  out  1  accumulator clear.
- sub  out  1  0 = add, 1 = subtract.
- Halt  out  1  processor halted.
- state  out  4  current state code (debug).
- instr_count  out  CNT_W  instructions retired.

Behaviour:
- Opcodes:
  - 000 LOAD, 001 STORE, 010 ADD, 011 SUB
  - 100 INPUT, 101 JZ, 110 JPOS, 111 HALT
- States:
  - START, FETCH, DECODE
  - LOAD, STORE, ADD, SUB
  - INPUT_WAIT, INPUT_LOAD
  - JZ, JPOS, HALT
- Outputs are Moore, decoded from state. Exceptions: in JZ and JPOS, PCload is combinational on the flag.
- Any output not listed for a state is 0, with Asel = 0.
- Reset: clear=1 forces state=START immediately. In START, clearA=1 and clearPC=1, all other outputs 0. instr_count=0 and the synchroniser flops are 0.
- START: always go to FETCH.
- FETCH: Meminst=1, IRload=1, PCload=1, JMPmux=0. Go to DECODE.
- DECODE: Meminst=0, so the operand address comes from IR. Branch on opcode to the matching state; opcode 100 goes to INPUT_WAIT.
- LOAD: Asel=2, loadA=1.
- STORE: Meminst=0, MemWr=1.
- ADD: Asel=0, sub=0, loadA=1.
- SUB: Asel=0, sub=1, loadA=1.
- JZ: JMPmux=1; PCload=Aeq0.
- JPOS: JMPmux=1; PCload=Apos.
- All execution states above go to FETCH next cycle.
- Latency: 3 cycles per instruction (FETCH, DECODE, execute), except INPUT and HALT.
- INPUT_WAIT: Asel=1.
  - Stay until a synchronised Enter rising edge is detected while in this state; then go to INPUT_LOAD.
  - Edges occurring in any other state are discarded.
  - If Enter is already high on entry, a release and re-press is required.
- INPUT_LOAD: Asel=1, loadA=1. Go to FETCH.
- Enter path: 2-flop synchroniser plus one delay flop. Edge = sync & ~delayed. Minimum response is 3 clocks after the Enter assertion.
- HALT: Halt=1. Remains in HALT until clear. Enter and the flags are ignored.
- instr_count:
  - Increments by 1 on every transition into FETCH from an execution state, including INPUT_LOAD.
  - Does not increment from START or for HALT.
  - Wraps 2^CNT_W-1 -> 0.
- Reset mid-operation: asynchronous return to START. No memory write or A load may be asserted after clear rises.
- Unused state codes decode to START on the next clock.

Decomposition:
- Shared package processor_pkg:
  - opcode constants (OP_LOAD..OP_HALT)
  - Asel encodings (ASEL_SUB, ASEL_INPUT, ASEL_MEM, ASEL_ZERO)
  - 4-bit state encoding constants
- One sub-module, enter_sync_edge: synchroniser plus rising-edge detector, with clk/clear, output enter_pulse.

Test Plan:
- Reset: clear pulse, then release -> START for 1 cycle with clearA=1 and clearPC=1; next cycle FETCH with IRload=PCload=Meminst=1; instr_count=0.
- Arithmetic: IR=010_00011 then 011_00100 -> ADD state asserts Asel=0, sub=0, loadA=1; SUB state asserts sub=1, loadA=1; each instruction 3 cycles; instr_count +2.
- Jumps:
  - IR=101_01010 with Aeq0=1 -> PCload=1, JMPmux=1 in the JZ state.
  - With Aeq0=0 -> PCload=0.
  - Same pair of checks for JPOS using Apos.
- INPUT handshake:
  - IR=100_00000 with Enter held high on entry -> stays in INPUT_WAIT.
  - Release and re-press -> INPUT_LOAD 3-4 clocks later with Asel=1, loadA=1, then FETCH.
- Halt and reset: IR=111_00000 -> Halt=1 held for 20 cycles with no further strobes; clear mid-HALT -> START immediately.
- Counter wrap: run 256 ADD instructions -> instr_count wraps 255 -> 0.
- Reset during STORE -> MemWr drops asynchronously.
